uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver matching the team's UART transmitter. It oversamples the serial line at 16 ticks per bit, using the shared baud-tick generator. Each frame it deserializes start + DATA_WIDTH data bits (LSB first) + optional parity + STOP_WIDTH stop bits, and presents the received byte with a one-cycle done pulse and error flags. It sits between the board RX pin and the interface/ALU control logic.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..8)
- STOP_WIDTH, 1, stop bits per frame (1 or 2)
- PARITY_WIDTH, 1, 0 = no parity bit, 1 = one parity bit
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_WIDTH = 0)
- i_clock  input  1  system clock; all logic on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_tick  input  1  baud tick, 16 per bit period, one clock wide
- i_rx  input  1  serial line, idle high, asynchronous to i_clock
- o_data_byte  output  DATA_WIDTH  last received data word; held until the next frame completes
- o_rx_done  output  1  one-cycle pulse when a frame completes
- o_parity_err  output  1  parity mismatch on the last frame; valid with o_rx_done, held
- o_frame_err  output  1  stop bit sampled low on the last frame; valid with o_rx_done, held

## Operation
- i_rx passes through a 2-flop synchronizer, reset to 1; rx_s denotes the synchronized value. All decisions use rx_s.
- tick_counter is 4 bits. It advances only on clocks where i_tick = 1 and is cleared on every state entry.
- State machine: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - Counters cleared.
  - If armed and rx_s = 0, go to START.
  - armed is set whenever rx_s = 1.
  - armed is cleared on any frame error (break / stuck-low protection).
- START:
  - On the tick where tick_counter = 7 (mid start bit): if rx_s = 0, clear the counter and go to DATA; if rx_s = 1, treat it as a glitch and return to IDLE with no done pulse.
- DATA:
  - On the tick where tick_counter = 15, sample rx_s into shift-register bit data_index (LSB first).
  - Increment data_index; after bit DATA_WIDTH-1, go to PARITY if PARITY_WIDTH = 1, else STOP.
- PARITY:
  - On the tick where tick_counter = 15, sample the parity bit.
  - parity_err = (XOR of data bits ^ sampled bit) != PARITY_ODD.
- STOP:
  - On each tick where tick_counter = 15, sample one stop bit; frame_err accumulates as OR of (rx_s == 0).
  - After STOP_WIDTH samples, go to DONE.
  - No wait for the end of the stop bit; this gives resync margin for back-to-back frames.
- DONE:
  - Lasts one clock.
  - Loads o_data_byte, o_parity_err, o_frame_err.
  - Pulses o_rx_done = 1, then goes to IDLE.
- Any unreachable state encoding returns to IDLE on the next clock.
- Errors never suppress o_rx_done; the received data is always delivered.

## Timing
- Reset values:
  - o_data_byte = 0, o_rx_done = 0, o_parity_err = 0, o_frame_err = 0.
  - State IDLE, armed = 1, synchronizer = 1.
- Reset is asynchronous and may assert mid-frame; the partial frame is discarded and no done pulse is produced.
- Detection latency: a falling edge on i_rx is seen in IDLE 2 clocks later (synchronizer).
- Frame latency, from entering START to the o_rx_done pulse:
  - 8 + 16·(DATA_WIDTH + PARITY_WIDTH + STOP_WIDTH) ticks, plus 1 clock for DONE.
  - Default configuration: 8 + 16·10 = 168 ticks + 1 clock.
- o_rx_done is exactly one clock wide, even if i_tick is high every clock.
- Outputs update only in DONE. Between frames, o_data_byte and the error flags keep their last values.
- i_tick held permanently high is legal: one tick per clock.
- i_tick low stalls the FSM in its current state indefinitely; no timeout.

## Test plan
- Reset and idle: i_reset low mid-stream, then released with i_rx = 1 for 1000 clocks -> all outputs 0, no o_rx_done.
- Single frame, default parameters: send 0xA5 with even parity 0 and 1 stop bit, i_tick every 4 clocks -> exactly one o_rx_done; o_data_byte = 0xA5, o_parity_err = 0, o_frame_err = 0; pulse 168 ticks after START entry.
- Parity error: send 0x3C with the parity bit forced to 1 (even parity) -> o_data_byte = 0x3C, o_parity_err = 1. Repeat with PARITY_ODD = 1 and parity bit 1 -> o_parity_err = 0.
- Glitch and break:
  - 3-tick low pulse on i_rx -> return to IDLE, no o_rx_done.
  - i_rx held low for 20 bit times -> one o_rx_done with o_data_byte = 0x00 and o_frame_err = 1; no further frames until i_rx returns high; a following 0x55 frame is received cleanly.
- Back-to-back frames: 0x01, 0xFF, 0x80 sent with no idle gap, TX clock 2% fast -> three done pulses with the correct bytes and no errors. Repeat with STOP_WIDTH = 2 and the second stop bit driven low -> o_frame_err = 1.
- Reset mid-frame: assert i_reset during data bit 4 of 0xC3, release, then send 0x5A -> no pulse for the aborted frame; one pulse with o_data_byte = 0x5A.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial-line side of the UART receiver: line and baud tick in, received word and status out.
// The master drives the line and the tick; the slave is the receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_tick;
  logic                  i_rx;
  logic [DATA_WIDTH-1:0] o_data_byte;
  logic                  o_rx_done;
  logic                  o_parity_err;
  logic                  o_frame_err;

  modport master (
    output i_tick, i_rx,
    input  o_data_byte, o_rx_done, o_parity_err, o_frame_err
  );
  modport slave (
    input  i_tick, i_rx,
    output o_data_byte, o_rx_done, o_parity_err, o_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start, DATA_WIDTH bits LSB first, optional parity, STOP_WIDTH stops.
// Results are loaded in DONE and appear with a one-clock o_rx_done pulse.
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_WIDTH   = 1,
  parameter int PARITY_WIDTH = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic      i_clock,
  input  logic      i_reset,
  uart_rx_if.slave  rx_if
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
    S_PARITY = 3'd3, S_STOP = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t                r_state, w_next;
  logic                  r_rx_meta, r_rx_s, r_armed;
  logic [3:0]            r_tick_cnt;
  logic [IW-1:0]         r_bit_idx;
  logic                  r_stop_idx;
  logic [DATA_WIDTH-1:0] r_shift, r_data;
  logic                  r_par_err, r_frame_err, r_par_out, r_frame_out, r_done;
  logic                  w_mid, w_end, w_last_bit, w_last_stop;
  logic                  w_smp_data, w_smp_par, w_smp_stop, w_load;

  assign w_mid       = rx_if.i_tick && (r_tick_cnt == 4'd7);
  assign w_end       = rx_if.i_tick && (r_tick_cnt == 4'd15);
  assign w_last_bit  = (r_bit_idx == IW'(DATA_WIDTH - 1));
  assign w_last_stop = (STOP_WIDTH == 1) || r_stop_idx;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_if.i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_armed && !r_rx_s) w_next = S_START;
      S_START:  if (w_mid) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_end && w_last_bit) w_next = (PARITY_WIDTH != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_end) w_next = S_STOP;
      S_STOP:   if (w_end && w_last_stop) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_smp_data = (r_state == S_DATA)   && w_end;
    w_smp_par  = (r_state == S_PARITY) && w_end;
    w_smp_stop = (r_state == S_STOP)   && w_end;
    w_load     = (r_state == S_DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt  <= '0;
      r_armed     <= 1'b1;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_data      <= '0;
      r_par_out   <= 1'b0;
      r_frame_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_load;
      if (r_state != w_next || r_state == S_IDLE) r_tick_cnt <= '0;
      else if (rx_if.i_tick)                      r_tick_cnt <= r_tick_cnt + 4'd1;
      // A low stop bit disarms until the line is seen high again, so a held break yields one frame.
      if (w_load && r_frame_err) r_armed <= 1'b0;
      else if (r_rx_s)           r_armed <= 1'b1;
      if (r_state == S_IDLE) begin
        r_bit_idx   <= '0;
        r_stop_idx  <= 1'b0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_smp_data) begin
        r_shift[r_bit_idx] <= r_rx_s;
        r_bit_idx          <= r_bit_idx + 1'b1;
      end
      if (w_smp_par)
        r_par_err <= ((^r_shift) ^ r_rx_s) != (PARITY_ODD != 0);
      if (w_smp_stop) begin
        r_frame_err <= r_frame_err | ~r_rx_s;
        r_stop_idx  <= ~r_stop_idx;
      end
      if (w_load) begin
        r_data      <= r_shift;
        r_par_out   <= r_par_err;
        r_frame_out <= r_frame_err;
      end
    end
  end

  assign rx_if.o_data_byte  = r_data;
  assign rx_if.o_rx_done    = r_done;
  assign rx_if.o_parity_err = r_par_out;
  assign rx_if.o_frame_err  = r_frame_out;
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: dut0 is 8E1, dut1 is 8O2.
// Expected results come from a frame-level model of what the line carried.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(8)) if0 ();
  uart_rx_if #(.DATA_WIDTH(8)) if1 ();

  uart_rx #(.DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY_WIDTH(1), .PARITY_ODD(0))
    dut0 (.i_clock(clk), .i_reset(rst_n), .rx_if(if0));
  uart_rx #(.DATA_WIDTH(8), .STOP_WIDTH(2), .PARITY_WIDTH(1), .PARITY_ODD(1))
    dut1 (.i_clock(clk), .i_reset(rst_n), .rx_if(if1));

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         tk;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_div = 4;
  int   div_cnt = 0;
  int   tick_total = 0;
  int   fall_tk = 0;
  logic tick = 1'b0;
  int   done0 = 0, done1 = 0, wide = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  res_t q0[$], q1[$];

  assign if0.i_tick = tick;
  assign if1.i_tick = tick;

  always @(posedge clk) begin
    if (tick) tick_total <= tick_total + 1;
    if (div_cnt >= tick_div - 1) begin div_cnt <= 0; tick <= 1'b1; end
    else begin div_cnt <= div_cnt + 1; tick <= 1'b0; end
  end

  always @(negedge clk) begin
    res_t r;
    if (if0.o_rx_done) begin
      r.d = if0.o_data_byte; r.pe = if0.o_parity_err; r.fe = if0.o_frame_err;
      r.tk = tick_total - fall_tk;
      q0.push_back(r); done0++;
    end
    if (if1.o_rx_done) begin
      r.d = if1.o_data_byte; r.pe = if1.o_parity_err; r.fe = if1.o_frame_err;
      r.tk = tick_total - fall_tk;
      q1.push_back(r); done1++;
    end
    if ((if0.o_rx_done && prev0) || (if1.o_rx_done && prev1)) wide++;
    prev0 = if0.o_rx_done;
    prev1 = if1.o_rx_done;
  end

  // Frame-level reference: parity error if data+parity ones disagree with the mode; any low stop is a frame error.
  function automatic res_t model(input logic [7:0] d, input logic pbit,
                                 input logic [1:0] stops, input int nstop, input bit odd);
    res_t e;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(pbit);
    e.d  = d;
    e.pe = ((ones % 2) == 1) != odd;
    e.fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    e.tk = 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) if0.i_rx = v; else if1.i_rx = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops, input int nstop, input int bclk);
    logic [11:0] bits;
    bits = {stops[1], stops[0], pbit, d, 1'b0};
    fall_tk = tick_total;
    for (int i = 0; i < 10 + nstop; i++) begin
      set_rx(which, bits[i]);
      idle(bclk);
    end
    set_rx(which, 1'b1);
  endtask

  task automatic wait_cnt(input int which, input int target, input int maxclk);
    for (int i = 0; i < maxclk; i++) begin
      if (((which == 0) ? done0 : done1) >= target) break;
      idle(1);
    end
  endtask

  task automatic expect_frame(input int which, input string tag, input res_t e, output res_t r);
    int sz;
    sz = (which == 0) ? q0.size() : q1.size();
    r = '{d: 8'h00, pe: 1'b0, fe: 1'b0, tk: 0};
    check({tag, "_rx"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (which == 0) r = q0.pop_front(); else r = q1.pop_front();
      check({tag, "_data"}, 32'(r.d), 32'(e.d));
      check({tag, "_perr"}, 32'(r.pe), 32'(e.pe));
      check({tag, "_ferr"}, 32'(r.fe), 32'(e.fe));
    end
  endtask

  initial begin
    res_t r;
    int   base;
    logic [7:0] d;
    logic pbit;
    logic [1:0] stp;
    if0.i_rx = 1'b1;
    if1.i_rx = 1'b1;
    idle(5);
    check("rst_data", 32'(if0.o_data_byte), 32'h0);
    check("rst_perr", 32'(if0.o_parity_err), 32'h0);
    check("rst_ferr", 32'(if0.o_frame_err), 32'h0);
    check("rst_done", 32'(if0.o_rx_done), 32'h0);
    rst_n = 1'b1;
    idle(20);

    base = done0;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1, 64);
    wait_cnt(0, base + 1, 400);
    idle(100);
    check("a5_count", 32'(done0 - base), 32'd1);
    expect_frame(0, "a5", model(8'hA5, 1'b0, 2'b11, 1, 1'b0), r);
    check("a5_latency", 32'(r.tk >= 168 && r.tk <= 169), 32'd1);

    send_frame(0, 8'h3C, 1'b1, 2'b11, 1, 64);
    wait_cnt(0, base + 2, 400);
    expect_frame(0, "par_even", model(8'h3C, 1'b1, 2'b11, 1, 1'b0), r);
    send_frame(1, 8'h3C, 1'b1, 2'b11, 2, 64);
    wait_cnt(1, 1, 400);
    expect_frame(1, "par_odd", model(8'h3C, 1'b1, 2'b11, 2, 1'b1), r);

    base = done0;
    set_rx(0, 1'b0); idle(12); set_rx(0, 1'b1);
    idle(300);
    check("glitch_nodone", 32'(done0 - base), 32'd0);

    base = done0;
    set_rx(0, 1'b0); idle(20 * 64); set_rx(0, 1'b1);
    idle(100);
    check("break_count", 32'(done0 - base), 32'd1);
    expect_frame(0, "break", model(8'h00, 1'b0, 2'b00, 1, 1'b0), r);
    send_frame(0, 8'h55, ^8'h55, 2'b11, 1, 64);
    wait_cnt(0, base + 2, 400);
    expect_frame(0, "after_break", model(8'h55, ^8'h55, 2'b11, 1, 1'b0), r);

    base = done0;
    send_frame(0, 8'h01, ^8'h01, 2'b11, 1, 63);
    send_frame(0, 8'hFF, ^8'hFF, 2'b11, 1, 63);
    send_frame(0, 8'h80, ^8'h80, 2'b11, 1, 63);
    wait_cnt(0, base + 3, 400);
    idle(50);
    check("b2b_count", 32'(done0 - base), 32'd3);
    expect_frame(0, "b2b_01", model(8'h01, ^8'h01, 2'b11, 1, 1'b0), r);
    expect_frame(0, "b2b_ff", model(8'hFF, ^8'hFF, 2'b11, 1, 1'b0), r);
    expect_frame(0, "b2b_80", model(8'h80, ^8'h80, 2'b11, 1, 1'b0), r);

    send_frame(1, 8'h12, ~^8'h12, 2'b01, 2, 64);
    wait_cnt(1, 2, 400);
    idle(50);
    expect_frame(1, "stop2_low", model(8'h12, ~^8'h12, 2'b01, 2, 1'b1), r);

    tick_div = 1;
    idle(20);
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom);
      pbit = (^d) ^ 1'($urandom_range(0, 1));
      stp  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      base = done0;
      send_frame(0, d, pbit, stp, 1, 16);
      wait_cnt(0, base + 1, 200);
      idle($urandom_range(2, 40));
      expect_frame(0, "rand", model(d, pbit, stp, 1, 1'b0), r);
    end
    tick_div = 4;
    idle(20);

    base = done0;
    d = 8'hC3;
    set_rx(0, 1'b0); idle(64);
    for (int i = 0; i < 4; i++) begin set_rx(0, d[i]); idle(64); end
    set_rx(0, d[4]); idle(32);
    rst_n = 1'b0;
    idle(3);
    check("midrst_data", 32'(if0.o_data_byte), 32'h0);
    check("midrst_ferr", 32'(if0.o_frame_err), 32'h0);
    rst_n = 1'b1;
    set_rx(0, 1'b1);
    idle(1000);
    check("midrst_nodone", 32'(done0 - base), 32'd0);
    check("idle_data", 32'(if0.o_data_byte), 32'h0);
    check("idle_perr", 32'(if0.o_parity_err), 32'h0);
    send_frame(0, 8'h5A, ^8'h5A, 2'b11, 1, 64);
    wait_cnt(0, base + 1, 400);
    idle(50);
    check("5a_count", 32'(done0 - base), 32'd1);
    expect_frame(0, "5a", model(8'h5A, ^8'h5A, 2'b11, 1, 1'b0), r);

    check("done_width", 32'(wide), 32'd0);
    check("q0_extra", 32'(q0.size()), 32'd0);
    check("q1_extra", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
